// File: rtl/sci_acc_pkg.sv
// Shared operation-packet definitions for the Maclaurin accelerator: field widths, packet struct, mode codes.
// Also imported by sci_acc_maclauren_exp_ctrl, so mode encodings must stay one-hot and stable.
package sci_acc_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_MODES  = 4;
  localparam int RES_WIDTH  = 4;

  localparam logic [NUM_MODES-1:0] MODE_EXP  = 4'b0001;
  localparam logic [NUM_MODES-1:0] MODE_SIN  = 4'b0010;
  localparam logic [NUM_MODES-1:0] MODE_COS  = 4'b0100;
  localparam logic [NUM_MODES-1:0] MODE_SINH = 4'b1000;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [NUM_MODES-1:0]  mode;
    logic [RES_WIDTH-1:0]  res;
  } op_pkt_t;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  function automatic logic mode_is_onehot(input logic [NUM_MODES-1:0] m);
    return (m != '0) && ((m & (m - NUM_MODES'(1))) == '0);
  endfunction

endpackage

// File: rtl/sci_acc_op_fifo_mem.sv
// Packet storage for the op input FIFO: one synchronous write port, one asynchronous read port.
// No reset on the array; validity is tracked entirely by the pointers in the parent.
module sci_acc_op_fifo_mem
  import sci_acc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  op_pkt_t       wr_pkt,
  input  logic [AW-1:0] rd_addr,
  output op_pkt_t       rd_pkt
);

  op_pkt_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_pkt;
  end

  assign rd_pkt = mem[rd_addr];

endmodule

// File: rtl/sci_acc_op_in_fifo.sv
// FWFT op-packet FIFO feeding the Maclaurin core; head visible 1 cycle after push, wr_ready = !full.
// Optional high-water mark (hwm/hwm_clr) is built when SCI_ACC_IN_FIFO_HWM_EN is defined.
module sci_acc_op_in_fifo
  import sci_acc_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_MODES-1:0]  wr_mode,
  input  logic [RES_WIDTH-1:0]  wr_res,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] in_fifo_data_o,
  output logic [NUM_MODES-1:0]  in_fifo_mode_o,
  output logic [RES_WIDTH-1:0]  in_fifo_res_o,
  output logic                  op_pkt_available,
  input  logic                  fifo_pop,
  output logic [CNT_W-1:0]      level,
  output logic                  err_overflow,
  output logic                  err_mode
`ifdef SCI_ACC_IN_FIFO_HWM_EN
 ,output logic [CNT_W-1:0]      hwm,
  input  logic                  hwm_clr
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [CNT_W-1:0] wr_ptr, rd_ptr;
  logic             empty, full, mode_ok, push, pop;
  op_pkt_t          wr_pkt, rd_pkt, head;

  // Extra wrap bit distinguishes full from empty when the address bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign mode_ok = mode_is_onehot(wr_mode);
  assign push    = wr_en && !full && mode_ok;
  assign pop     = fifo_pop && !empty;

  assign wr_pkt = '{data: wr_data, mode: wr_mode, res: wr_res};

  sci_acc_op_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_pkt  (wr_pkt),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_pkt  (rd_pkt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      err_overflow <= 1'b0;
      err_mode     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CNT_W'(1);
      if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
      if (push && !pop)      level <= level + CNT_W'(1);
      else if (pop && !push) level <= level - CNT_W'(1);
      if (wr_en && full) err_overflow <= 1'b1;
      // Overflow outranks a bad mode: a push into a full FIFO only raises err_overflow.
      err_mode <= wr_en && !full && !mode_ok;
    end
  end

`ifdef SCI_ACC_IN_FIFO_HWM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         hwm <= '0;
    else if (hwm_clr)     hwm <= level;
    else if (level > hwm) hwm <= level;
  end
`endif

  // Head is gated to zero when empty so stale array contents never leak out.
  assign head             = empty ? '0 : rd_pkt;
  assign in_fifo_data_o   = head.data;
  assign in_fifo_mode_o   = head.mode;
  assign in_fifo_res_o    = head.res;
  assign op_pkt_available = !empty;
  assign wr_ready         = !full;

endmodule

// File: tb/tb_sci_acc_op_in_fifo.sv
// Randomised bench for sci_acc_op_in_fifo (DEPTH=4) against a queue-based packet model.
module tb_sci_acc_op_in_fifo;
  import sci_acc_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  wr_en = 1'b0;
  logic [DATA_WIDTH-1:0] wr_data = '0;
  logic [NUM_MODES-1:0]  wr_mode = '0;
  logic [RES_WIDTH-1:0]  wr_res = '0;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] in_fifo_data_o;
  logic [NUM_MODES-1:0]  in_fifo_mode_o;
  logic [RES_WIDTH-1:0]  in_fifo_res_o;
  logic                  op_pkt_available;
  logic                  fifo_pop = 1'b0;
  logic [CNT_W-1:0]      level;
  logic                  err_overflow;
  logic                  err_mode;
`ifdef SCI_ACC_IN_FIFO_HWM_EN
  logic [CNT_W-1:0]      hwm;
  logic                  hwm_clr = 1'b0;
`endif

  sci_acc_op_in_fifo #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .wr_en            (wr_en),
    .wr_data          (wr_data),
    .wr_mode          (wr_mode),
    .wr_res           (wr_res),
    .wr_ready         (wr_ready),
    .in_fifo_data_o   (in_fifo_data_o),
    .in_fifo_mode_o   (in_fifo_mode_o),
    .in_fifo_res_o    (in_fifo_res_o),
    .op_pkt_available (op_pkt_available),
    .fifo_pop         (fifo_pop),
    .level            (level),
    .err_overflow     (err_overflow),
    .err_mode         (err_mode)
`ifdef SCI_ACC_IN_FIFO_HWM_EN
   ,.hwm              (hwm),
    .hwm_clr          (hwm_clr)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: packets in arrival order, sticky overflow, expected err_mode pulse, high-water mark.
  op_pkt_t q[$];
  logic    m_ovf = 1'b0;
  logic    m_errm = 1'b0;
  int      m_hwm = 0;

  function automatic logic [NUM_MODES-1:0] rand_onehot();
    logic [NUM_MODES-1:0] m;
    m = '0;
    m[$urandom_range(NUM_MODES-1, 0)] = 1'b1;
    return m;
  endfunction

  function automatic op_pkt_t exp_head();
    op_pkt_t p;
    p = '0;
    if (q.size() > 0) p = q[0];
    return p;
  endfunction

  // One clock: inputs driven from the negedge, model advanced at the posedge, outputs idle again at next negedge.
  task automatic cycle(input logic en, input logic [DATA_WIDTH-1:0] d, input logic [NUM_MODES-1:0] m,
                       input logic [RES_WIDTH-1:0] r, input logic pop);
    int  sz;
    logic ok;
    wr_en = en; wr_data = d; wr_mode = m; wr_res = r; fifo_pop = pop;
    @(posedge clk);
    sz = q.size();
    ok = ($countones(m) == 1);
    if (sz > m_hwm) m_hwm = sz;
    m_errm = en && (sz < DEPTH) && !ok;
    if (en && sz == DEPTH) m_ovf = 1'b1;
    if (pop && sz > 0) void'(q.pop_front());
    if (en && sz < DEPTH && ok) q.push_back('{data: d, mode: m, res: r});
    @(negedge clk);
    wr_en = 1'b0; fifo_pop = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++; if (op_pkt_available !== 1'b0) begin failures++; $display("FAIL reset_avail got=%b exp=0", op_pkt_available); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    checks++; if (level !== '0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if ({in_fifo_data_o, in_fifo_mode_o, in_fifo_res_o} !== '0) begin failures++; $display("FAIL reset_head got=%h exp=0", {in_fifo_data_o, in_fifo_mode_o, in_fifo_res_o}); end
    checks++; if ({err_overflow, err_mode} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", {err_overflow, err_mode}); end
    @(negedge clk);
    reset_n = 1'b1;
    q.delete(); m_ovf = 1'b0; m_errm = 1'b0; m_hwm = 0;
  endtask

  task automatic test_first_push();
    cycle(1'b1, 32'h3F800000, 4'b0001, 4'd5, 1'b0);
    checks++; if (op_pkt_available !== 1'b1) begin failures++; $display("FAIL first_avail got=%b exp=1", op_pkt_available); end
    checks++; if (in_fifo_data_o !== 32'h3F800000) begin failures++; $display("FAIL first_data got=%h exp=3f800000", in_fifo_data_o); end
    checks++; if (in_fifo_mode_o !== 4'b0001 || in_fifo_res_o !== 4'd5) begin failures++; $display("FAIL first_mode_res got=%b/%0d exp=0001/5", in_fifo_mode_o, in_fifo_res_o); end
    checks++; if (level !== CNT_W'(1)) begin failures++; $display("FAIL first_level got=%0d exp=1", level); end
    cycle(1'b0, '0, '0, '0, 1'b1);
    checks++; if (op_pkt_available !== 1'b0) begin failures++; $display("FAIL first_drain got=%b exp=0", op_pkt_available); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DATA_WIDTH'(i), rand_onehot(), RES_WIDTH'($urandom), 1'b0);
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL ovf_wr_ready got=%b exp=0", wr_ready); end
    cycle(1'b1, 32'd5, 4'b0010, 4'd1, 1'b0);
    checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", err_overflow); end
    checks++; if (level !== CNT_W'(DEPTH)) begin failures++; $display("FAIL ovf_level got=%0d exp=%0d", level, DEPTH); end
    // Push with bad mode while full: overflow only, no err_mode pulse.
    cycle(1'b1, 32'd6, 4'b0011, 4'd1, 1'b0);
    checks++; if (err_mode !== 1'b0) begin failures++; $display("FAIL ovf_prio_errmode got=%b exp=0", err_mode); end
    idle();
    checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", err_overflow); end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (in_fifo_data_o !== DATA_WIDTH'(i)) begin failures++; $display("FAIL ovf_order%0d got=%h exp=%h", i, in_fifo_data_o, i); end
      cycle(1'b0, '0, '0, '0, 1'b1);
    end
    checks++; if (op_pkt_available !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", op_pkt_available); end
  endtask

  task automatic test_back_to_back();
    op_pkt_t e;
    cycle(1'b1, $urandom, rand_onehot(), RES_WIDTH'($urandom), 1'b0);
    cycle(1'b1, $urandom, rand_onehot(), RES_WIDTH'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, $urandom, rand_onehot(), RES_WIDTH'($urandom), 1'b1);
      e = exp_head();
      checks++; if (level !== CNT_W'(2)) begin failures++; $display("FAIL b2b_level%0d got=%0d exp=2", i, level); end
      checks++; if ({in_fifo_data_o, in_fifo_mode_o, in_fifo_res_o} !== e) begin failures++; $display("FAIL b2b_head%0d got=%h exp=%h", i, {in_fifo_data_o, in_fifo_mode_o, in_fifo_res_o}, e); end
    end
    cycle(1'b0, '0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic test_bad_mode();
    logic [NUM_MODES-1:0] bad [2];
    bad[0] = 4'b0011; bad[1] = 4'b0000;
    cycle(1'b1, 32'hA5A5A5A5, 4'b0100, 4'd3, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, $urandom, bad[i], 4'd7, 1'b0);
      checks++; if (err_mode !== 1'b1) begin failures++; $display("FAIL badmode_pulse%0d got=%b exp=1", i, err_mode); end
      checks++; if (level !== CNT_W'(1)) begin failures++; $display("FAIL badmode_level%0d got=%0d exp=1", i, level); end
      idle();
      checks++; if (err_mode !== 1'b0) begin failures++; $display("FAIL badmode_clear%0d got=%b exp=0", i, err_mode); end
    end
    checks++; if (in_fifo_data_o !== 32'hA5A5A5A5) begin failures++; $display("FAIL badmode_head got=%h exp=a5a5a5a5", in_fifo_data_o); end
    cycle(1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic test_empty_ops();
    cycle(1'b0, '0, '0, '0, 1'b1);
    checks++; if (level !== '0 || op_pkt_available !== 1'b0) begin failures++; $display("FAIL emptypop got=%0d/%b exp=0/0", level, op_pkt_available); end
    cycle(1'b1, 32'h12345678, 4'b1000, 4'd9, 1'b1);
    checks++; if (level !== CNT_W'(1)) begin failures++; $display("FAIL emptypushpop_level got=%0d exp=1", level); end
    checks++; if (in_fifo_data_o !== 32'h12345678 || in_fifo_mode_o !== 4'b1000) begin failures++; $display("FAIL emptypushpop_head got=%h/%b exp=12345678/1000", in_fifo_data_o, in_fifo_mode_o); end
    cycle(1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic test_random();
    op_pkt_t e;
    logic [NUM_MODES-1:0] m;
    for (int i = 0; i < 300; i++) begin
      m = ($urandom_range(7, 0) == 0) ? NUM_MODES'($urandom) : rand_onehot();
      cycle($urandom_range(1, 0) == 1, $urandom, m, RES_WIDTH'($urandom), $urandom_range(2, 0) == 0);
      e = exp_head();
      checks++; if (level !== CNT_W'(q.size())) begin failures++; $display("FAIL rnd_level%0d got=%0d exp=%0d", i, level, q.size()); end
      checks++; if ({in_fifo_data_o, in_fifo_mode_o, in_fifo_res_o} !== e) begin failures++; $display("FAIL rnd_head%0d got=%h exp=%h", i, {in_fifo_data_o, in_fifo_mode_o, in_fifo_res_o}, e); end
      checks++; if ({op_pkt_available, wr_ready} !== {q.size() != 0, q.size() != DEPTH}) begin failures++; $display("FAIL rnd_flags%0d got=%b exp=%b", i, {op_pkt_available, wr_ready}, {q.size() != 0, q.size() != DEPTH}); end
      checks++; if ({err_overflow, err_mode} !== {m_ovf, m_errm}) begin failures++; $display("FAIL rnd_err%0d got=%b exp=%b", i, {err_overflow, err_mode}, {m_ovf, m_errm}); end
    end
  endtask

  task automatic test_async_reset();
    while (q.size() > 0) cycle(1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, rand_onehot(), RES_WIDTH'($urandom), 1'b0);
    idle();
    checks++; if (level !== CNT_W'(3)) begin failures++; $display("FAIL arst_pre_level got=%0d exp=3", level); end
`ifdef SCI_ACC_IN_FIFO_HWM_EN
    checks++; if (hwm !== CNT_W'(m_hwm)) begin failures++; $display("FAIL arst_pre_hwm got=%0d exp=%0d", hwm, m_hwm); end
`endif
    #2 reset_n = 1'b0;
    #1;
    checks++; if (op_pkt_available !== 1'b0 || level !== '0) begin failures++; $display("FAIL arst_async got=%b/%0d exp=0/0", op_pkt_available, level); end
    checks++; if ({in_fifo_data_o, in_fifo_mode_o, in_fifo_res_o} !== '0) begin failures++; $display("FAIL arst_head got=%h exp=0", {in_fifo_data_o, in_fifo_mode_o, in_fifo_res_o}); end
    @(negedge clk);
    reset_n = 1'b1;
    q.delete(); m_ovf = 1'b0; m_errm = 1'b0; m_hwm = 0;
    idle();
    checks++; if (wr_ready !== 1'b1 || op_pkt_available !== 1'b0 || err_overflow !== 1'b0) begin failures++; $display("FAIL arst_post got=%b%b%b exp=100", wr_ready, op_pkt_available, err_overflow); end
`ifdef SCI_ACC_IN_FIFO_HWM_EN
    checks++; if (hwm !== '0) begin failures++; $display("FAIL arst_post_hwm got=%0d exp=0", hwm); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_push();
    test_overflow();
    test_back_to_back();
    test_bad_mode();
    test_empty_ops();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
